// File: rtl/led_pkg.sv
// Shared encodings for the LED arbiter: per-requester LED modes, arbiter FSM states,
// and the mode-to-drive helper.
package led_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'b00,
        LED_ON    = 2'b01,
        LED_BLINK = 2'b10,
        LED_RAPID = 2'b11
    } led_mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        OWN    = 2'b01,
        SWITCH = 2'b10
    } arb_state_e;

    function automatic logic mode_led(input logic [1:0] m, input logic blink, input logic rapid);
        logic drive;
        case (led_mode_e'(m))
            LED_OFF:   drive = 1'b0;
            LED_ON:    drive = 1'b1;
            LED_BLINK: drive = blink;
            LED_RAPID: drive = rapid;
            default:   drive = 1'b0;
        endcase
        return drive;
    endfunction

endpackage

// File: rtl/led_timebase.sv
// Free-running blink timebase with synchronous clear. Taps are taken from the next
// count so that a register loaded from them lines up with the counter itself.
module led_timebase #(
    parameter int CNT_W     = 26,
    parameter int BLINK_BIT = 25,
    parameter int RAPID_BIT = 24
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic blink_next,
    output logic rapid_next
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    assign cnt_next   = clr ? '0 : cnt + CNT_W'(1);
    assign blink_next = cnt_next[BLINK_BIT];
    assign rapid_next = cnt_next[RAPID_BIT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/led_arbiter.sv
// Round-robin owner of a single LED pin with minimum hold time before pre-emption.
// Optional dimming: define LED_PWM_EN to add the pwm_duty port and PWM gating.
//
//  state  | meaning
//  IDLE   | no owner, LED dark; grant the first requester at/after rr_ptr
//  OWN    | owner granted, LED follows the owner's mode, hold counter running
//  SWITCH | one-cycle dark gap between a pre-empted owner and the next one
module led_arbiter
    import led_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int CNT_W       = 26,
    parameter int BLINK_BIT   = 25,
    parameter int RAPID_BIT   = 24,
    parameter int HOLD_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] mode,
`ifdef LED_PWM_EN
    input  logic [7:0]        pwm_duty,
`endif
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              led
);

    localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NREQ - 1);

    arb_state_e        state;
    logic [IDX_W-1:0]  owner;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  pick;
    logic [IDX_W-1:0]  rr_after_owner;
    logic              found;
    logic [HOLD_W-1:0] hold;
    logic [HOLD_W-1:0] hold_inc;
    logic              enter_own;
    logic              blink_next;
    logic              rapid_next;
    logic [1:0]        owner_mode;
    logic [1:0]        pick_mode;
    logic [NREQ-1:0]   owner_mask;
    logic              others_req;
    logic              pwm_on;

    // Wrap is an explicit compare, so a non-power-of-2 NREQ never yields an out-of-range index.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = IDX_W'(idx);
            end
        end
    end

    assign owner_mask     = NREQ'(1) << owner;
    assign others_req     = |(req & ~owner_mask);
    assign hold_inc       = (hold == HOLD_MAX) ? hold : hold + HOLD_W'(1);
    assign rr_after_owner = (owner == LAST_IDX) ? '0 : owner + IDX_W'(1);
    assign owner_mode     = mode[{owner, 1'b0} +: 2];
    assign pick_mode      = mode[{pick, 1'b0} +: 2];
    assign enter_own      = (state != OWN) && found;

    led_timebase #(
        .CNT_W     (CNT_W),
        .BLINK_BIT (BLINK_BIT),
        .RAPID_BIT (RAPID_BIT)
    ) u_timebase (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (enter_own),
        .blink_next (blink_next),
        .rapid_next (rapid_next)
    );

`ifdef LED_PWM_EN
    logic [7:0] pwm_cnt;
    logic [7:0] pwm_cnt_next;
    logic [7:0] pwm_duty_q;
    logic [7:0] pwm_duty_next;

    // Duty only changes at the wrap so a period is never cut short or stretched.
    assign pwm_cnt_next  = pwm_cnt + 8'd1;
    assign pwm_duty_next = (pwm_cnt_next == 8'd0) ? pwm_duty : pwm_duty_q;
    assign pwm_on        = pwm_cnt_next < pwm_duty_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt    <= '0;
            pwm_duty_q <= '0;
        end else begin
            pwm_cnt    <= pwm_cnt_next;
            pwm_duty_q <= pwm_duty_next;
        end
    end
`else
    assign pwm_on = 1'b1;
`endif

    // Ownership counts the current cycle, so an owner is visible for exactly HOLD_CYCLES
    // cycles before a waiting requester can take over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            hold   <= '0;
            grant  <= '0;
            busy   <= 1'b0;
            led    <= 1'b0;
        end else begin
            case (state)
                IDLE, SWITCH: begin
                    if (found) begin
                        state <= OWN;
                        owner <= pick;
                        hold  <= '0;
                        grant <= NREQ'(1) << pick;
                        busy  <= 1'b1;
                        led   <= mode_led(pick_mode, blink_next, rapid_next) & pwm_on;
                    end else begin
                        state <= IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                        led   <= 1'b0;
                    end
                end
                OWN: begin
                    if (!req[owner]) begin
                        state  <= IDLE;
                        rr_ptr <= rr_after_owner;
                        grant  <= '0;
                        busy   <= 1'b0;
                        led    <= 1'b0;
                    end else if (others_req && (hold_inc == HOLD_MAX)) begin
                        state  <= SWITCH;
                        rr_ptr <= rr_after_owner;
                        hold   <= hold_inc;
                        grant  <= '0;
                        busy   <= 1'b0;
                        led    <= 1'b0;
                    end else begin
                        hold <= hold_inc;
                        led  <= mode_led(owner_mode, blink_next, rapid_next) & pwm_on;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                    led   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_arbiter.sv
// Directed bench for led_arbiter (default build, no PWM) with small timebase and hold.
module tb_led_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] req;
    logic [3:0] mode;
    logic [1:0] grant;
    logic       busy;
    logic       led;

    int checks;
    int fails;

    led_arbiter #(
        .NREQ        (2),
        .CNT_W       (6),
        .BLINK_BIT   (4),
        .RAPID_BIT   (3),
        .HOLD_CYCLES (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .mode  (mode),
        .grant (grant),
        .busy  (busy),
        .led   (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        req = 2'b00;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 2'b00;
        mode  = 4'b0000;
        tick();
        tick();
        checks++;
        if (grant !== 2'b00 || busy !== 1'b0 || led !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: grant=%b busy=%b led=%b expected grant=00 busy=0 led=0", grant, busy, led);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (grant !== 2'b00 || busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: grant=%b busy=%b expected 00/0", grant, busy);
        end
    endtask

    task automatic test_single();
        req  = 2'b01;
        mode = 4'b0001;
        tick();
        checks++;
        if (grant !== 2'b01 || busy !== 1'b1 || led !== 1'b1) begin
            fails++;
            $display("FAIL single_grant: grant=%b busy=%b led=%b expected 01/1/1", grant, busy, led);
        end
        tick();
        mode = 4'b0000;
        tick();
        checks++;
        if (led !== 1'b0 || grant !== 2'b01) begin
            fails++;
            $display("FAIL mode_off: led=%b grant=%b expected led=0 grant=01", led, grant);
        end
        mode = 4'b0001;
        tick();
        checks++;
        if (led !== 1'b1) begin
            fails++;
            $display("FAIL mode_on_again: led=%b expected 1", led);
        end
        req = 2'b00;
        #3;
        checks++;
        if (grant !== 2'b01) begin
            fails++;
            $display("FAIL drop_not_early: grant=%b expected 01", grant);
        end
        tick();
        checks++;
        if (grant !== 2'b00 || busy !== 1'b0 || led !== 1'b0) begin
            fails++;
            $display("FAIL single_drop: grant=%b busy=%b led=%b expected 00/0/0", grant, busy, led);
        end
    endtask

    task automatic test_blink();
        logic exp;
        int   bad;
        go_idle();
        mode = 4'b0010;
        req  = 2'b01;
        bad  = 0;
        for (int k = 0; k < 64; k++) begin
            tick();
            exp = ((k >> 4) & 1) != 0;
            checks++;
            if (led !== exp) begin
                fails++;
                bad++;
                if (bad < 5) $display("FAIL blink_led cycle %0d: led=%b expected %b", k, led, exp);
            end
        end
        go_idle();
        mode = 4'b0011;
        req  = 2'b01;
        bad  = 0;
        for (int k = 0; k < 32; k++) begin
            tick();
            exp = ((k >> 3) & 1) != 0;
            checks++;
            if (led !== exp) begin
                fails++;
                bad++;
                if (bad < 5) $display("FAIL rapid_led cycle %0d: led=%b expected %b", k, led, exp);
            end
        end
        go_idle();
    endtask

    task automatic test_preempt();
        logic [1:0] exp_g;
        logic       exp_l;
        // rr pointer is 1 here (owner 0 dropped last); seed owner 0 via a lone request from idle
        mode = 4'b0001;
        req  = 2'b01;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (k == 3) req = 2'b11;
            exp_g = (k < 8) ? 2'b01 : (k == 8) ? 2'b00 : 2'b10;
            exp_l = (k < 8);
            checks++;
            if (grant !== exp_g || led !== exp_l || busy !== (exp_g != 2'b00)) begin
                fails++;
                $display("FAIL preempt cycle %0d: grant=%b led=%b busy=%b expected grant=%b led=%b", k, grant, led, busy, exp_g, exp_l);
            end
        end
        req = 2'b10;
        for (int k = 0; k < 20; k++) begin
            tick();
            checks++;
            if (grant !== 2'b10) begin
                fails++;
                $display("FAIL sole_owner cycle %0d: grant=%b expected 10", k, grant);
            end
        end
        go_idle();
    endtask

    task automatic test_fairness();
        logic [1:0] exp_g;
        int         pos;
        mode = 4'b0001;
        req  = 2'b11;
        for (int c = 0; c < 54; c++) begin
            tick();
            pos   = c % 18;
            exp_g = (pos < 8) ? 2'b01 : (pos == 8) ? 2'b00 : (pos < 17) ? 2'b10 : 2'b00;
            checks++;
            if (grant !== exp_g || led !== (exp_g == 2'b01)) begin
                fails++;
                $display("FAIL fairness cycle %0d: grant=%b led=%b expected grant=%b", c, grant, led, exp_g);
            end
        end
        go_idle();
    endtask

    task automatic test_back_to_back();
        req = 2'b01;
        tick();
        tick();
        checks++;
        if (grant !== 2'b01) begin
            fails++;
            $display("FAIL b2b_first: grant=%b expected 01", grant);
        end
        req = 2'b10;
        tick();
        checks++;
        if (grant !== 2'b00 || busy !== 1'b0) begin
            fails++;
            $display("FAIL b2b_gap: grant=%b busy=%b expected 00/0", grant, busy);
        end
        tick();
        checks++;
        if (grant !== 2'b10 || busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_second: grant=%b busy=%b expected 10/1", grant, busy);
        end
        go_idle();
    endtask

    task automatic test_reset_mid_own();
        mode = 4'b0101;
        req  = 2'b01;
        tick();
        req = 2'b00;
        tick();
        req = 2'b10;
        tick();
        tick();
        checks++;
        if (grant !== 2'b10 || led !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_owner: grant=%b led=%b expected 10/1", grant, led);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== 2'b00 || busy !== 1'b0 || led !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: grant=%b busy=%b led=%b expected 00/0/0", grant, busy, led);
        end
        #1;
        rst_n = 1'b1;
        req   = 2'b11;
        tick();
        checks++;
        if (grant !== 2'b01 || busy !== 1'b1) begin
            fails++;
            $display("FAIL rr_after_reset: grant=%b busy=%b expected 01/1", grant, busy);
        end
        go_idle();
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst_n  = 1'b0;
        req    = 2'b00;
        mode   = 4'b0000;
        test_reset();
        test_single();
        test_blink();
        test_preempt();
        test_fairness();
        test_back_to_back();
        test_reset_mid_own();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
